// File: rtl/int_arbiter_if.sv
// Port bus and request/acknowledge signals of int_arbiter.
// The processor side uses the master modport and the arbiter uses the slave modport.
interface int_arbiter_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0] src_in;
    logic [7:0]         port_id;
    logic [7:0]         out_port;
    logic               write_strobe;
    logic               interrupt_ack;
    logic               interrupt;
    logic [7:0]         rd_data;
    logic               sel;

    modport master (
        output src_in, port_id, out_port, write_strobe, interrupt_ack,
        input  interrupt, rd_data, sel
    );

    modport slave (
        input  src_in, port_id, out_port, write_strobe, interrupt_ack,
        output interrupt, rd_data, sel
    );
endinterface

// File: rtl/int_arbiter.sv
// Interrupt arbiter sitting in front of kcpsm6.
// It synchronises the raw event lines, latches their rising edges as pending bits,
// and masks them. It presents the highest-priority request and holds a service
// state until software writes end-of-interrupt.

// Per-source cell: synchroniser, edge detector and pending latch.
module int_arbiter_src (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic clr,
    output logic lvl,
    output logic pend
);
    logic s1, s2, prev, src_edge;

    // Two-flop synchroniser followed by a delay stage used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= src;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign src_edge = s2 & ~prev;
    assign lvl      = s2;

    // Pending latch. A fresh edge beats a clear that arrives in the same cycle,
    // so an event is never lost to a racing W1C or acknowledge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend <= 1'b0;
        else     pend <= src_edge | (pend & ~clr);
    end
endmodule

module int_arbiter #(
    parameter int          NUM_SRC    = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'h10,
    parameter logic [7:0]  RESET_MASK = 8'h00
) (
    input logic          clk,
    input logic          rst,
    int_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_SERVICE} state_t;

    state_t             state, state_nx;
    logic               intr_q;
    logic [NUM_SRC-1:0] pending, s2_lvl, mask, eligible;
    logic [NUM_SRC-1:0] wr_clr, ack_clr, clr;
    logic [2:0]         winner, vec_id;
    logic               vec_valid, any_elig, take_ack, in_service;
    logic               sel_hit, wr_en, eoi;
    logic [1:0]         offset;
    logic [7:0]         rd;
    logic               unused_wdata;

    // One synchroniser/pending cell per request line.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        int_arbiter_src u_src (
            .clk  (clk),
            .rst  (rst),
            .src  (bus.src_in[i]),
            .clr  (clr[i]),
            .lvl  (s2_lvl[i]),
            .pend (pending[i])
        );
    end

    // Port decode. The block owns four consecutive addresses.
    assign sel_hit = (bus.port_id[7:2] == BASE_ADDR[7:2]);
    assign offset  = bus.port_id[1:0];
    assign wr_en   = sel_hit & bus.write_strobe;
    assign eoi     = wr_en && (offset == 2'd2);
    assign wr_clr  = (wr_en && (offset == 2'd0)) ? bus.out_port[NUM_SRC-1:0] : '0;

    // Data bits above NUM_SRC have no storage behind them.
    assign unused_wdata = ^bus.out_port;

    assign eligible = pending & mask;
    assign any_elig = |eligible;

    // Fixed priority: the lowest index wins, so scan from the top down.
    always_comb begin
        winner = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (eligible[i]) winner = 3'(i);
    end

    // State register. The interrupt flop follows the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            intr_q <= 1'b0;
        end else begin
            state  <= state_nx;
            intr_q <= (state_nx == ST_ASSERT);
        end
    end

    // Next-state logic. An acknowledge takes precedence over the request vanishing.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (any_elig) state_nx = ST_ASSERT;
            ST_ASSERT: begin
                if (bus.interrupt_ack)  state_nx = ST_SERVICE;
                else if (!any_elig)     state_nx = ST_IDLE;
            end
            ST_SERVICE: if (eoi) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    // FSM outputs. An acknowledge only counts while a request is being presented.
    always_comb begin
        take_ack   = (state == ST_ASSERT) && bus.interrupt_ack;
        in_service = (state == ST_SERVICE);
    end

    // Build a one-hot clear for the source that was acknowledged.
    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++)
            ack_clr[i] = take_ack && any_elig && (winner == 3'(i));
    end

    assign clr = wr_clr | ack_clr;

    // Latch the vector when the acknowledge arrives. An empty acknowledge reports 7 and invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_id    <= 3'd0;
            vec_valid <= 1'b0;
        end else if (take_ack) begin
            vec_id    <= any_elig ? winner : 3'd7;
            vec_valid <= any_elig;
        end
    end

    // Software mask register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              mask <= RESET_MASK[NUM_SRC-1:0];
        else if (wr_en && (offset == 2'd1))   mask <= bus.out_port[NUM_SRC-1:0];
    end

    // Read-back mux. It drives zero when another block owns the port address.
    always_comb begin
        rd = 8'h00;
        if (sel_hit) begin
            case (offset)
                2'd0: rd[NUM_SRC-1:0] = pending;
                2'd1: rd[NUM_SRC-1:0] = mask;
                2'd2: rd = {vec_valid, in_service, 3'b000, vec_id};
                default: rd[NUM_SRC-1:0] = s2_lvl;
            endcase
        end
    end

    assign bus.rd_data   = rd;
    assign bus.sel       = sel_hit;
    assign bus.interrupt = intr_q;
endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter. It combines a register-access vector table,
// directed corner-case sequences and randomized traffic, all checked against a
// delay-line / mode reference model.
module tb_int_arbiter;
    localparam int         N     = 4;
    localparam logic [7:0] BASE  = 8'h10;
    localparam logic [7:0] RMASK = 8'h00;
    localparam int         FULL  = (1 << N) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    int_arbiter_if #(.NUM_SRC(N)) bus ();

    int_arbiter #(.NUM_SRC(N), .BASE_ADDR(BASE), .RESET_MASK(RMASK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model. hist[k] is the src_in value sampled k+1 clock edges ago.
    // m_mode 0 = idle, 1 = requesting, 2 = in service.
    int m_pend, m_mask, m_mode, m_vid, m_vv;
    int hist [3];

    function automatic int lowbit(input int v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_mask = int'(RMASK) & FULL; m_mode = 0; m_vid = 0; m_vv = 0;
        for (int i = 0; i < 3; i++) hist[i] = 0;
    endtask

    function automatic logic model_sel();
        return (bus.port_id[7:2] == BASE[7:2]);
    endfunction

    task automatic model_step();
        int elig, clr, edg, off, wr;
        if (rst) begin
            model_reset();
            return;
        end
        off  = int'(bus.port_id[1:0]);
        wr   = int'(model_sel() && bus.write_strobe);
        elig = m_pend & m_mask;
        edg  = hist[1] & ~hist[2];
        clr  = (wr != 0 && off == 0) ? (int'(bus.out_port) & FULL) : 0;
        case (m_mode)
            0: if (elig != 0) m_mode = 1;
            1: begin
                if (bus.interrupt_ack) begin
                    if (elig != 0) begin
                        m_vid = lowbit(elig); m_vv = 1; clr = clr | (1 << m_vid);
                    end else begin
                        m_vid = 7; m_vv = 0;
                    end
                    m_mode = 2;
                end else if (elig == 0) m_mode = 0;
            end
            default: if (wr != 0 && off == 2) m_mode = 0;
        endcase
        m_pend = (m_pend & ~clr) | edg;
        if (wr != 0 && off == 1) m_mask = int'(bus.out_port) & FULL;
        hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(bus.src_in);
    endtask

    function automatic logic [7:0] model_rd();
        logic [7:0] v;
        logic [2:0] id;
        id = 3'(m_vid);
        if (!model_sel()) return 8'h00;
        case (bus.port_id[1:0])
            2'd0:    v = 8'(m_pend);
            2'd1:    v = 8'(m_mask);
            2'd2:    v = {(m_vv != 0), (m_mode == 2), 3'b000, id};
            default: v = 8'(hist[1]);
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance one clock, step the model, and compare outputs on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model_interrupt", bus.interrupt, (m_mode == 1));
        chk("model_sel", bus.sel, model_sel());
        chk("model_rd_data", bus.rd_data, model_rd());
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] data);
        bus.port_id = addr; bus.out_port = data; bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0; bus.port_id = 8'h00; bus.out_port = 8'h00;
    endtask

    task automatic rd_chk(input string name, input logic [1:0] off, input logic [7:0] exp);
        bus.port_id = BASE + 8'(off);
        #1;
        chk(name, bus.rd_data, exp);
    endtask

    task automatic ack();
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
    endtask

    task automatic pulse(input logic [N-1:0] bits, input int len);
        bus.src_in = bits;
        repeat (len) tick();
        bus.src_in = '0;
    endtask

    task automatic wait_intr(input string name, input int maxc);
        int n = 0;
        while (!bus.interrupt && n < maxc) begin
            tick();
            n++;
        end
        chk(name, bus.interrupt, 1'b1);
    endtask

    typedef struct {
        logic [7:0] port;
        logic [7:0] data;
        logic       we;
        logic [7:0] exp_rd;
        logic       exp_sel;
    } vec_t;

    vec_t vt [16];

    initial begin
        // Register-access vectors, applied right after reset (nothing pending, IDLE).
        vt[0]  = '{8'h10, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[1]  = '{8'h11, 8'h00, 1'b0, RMASK, 1'b1};
        vt[2]  = '{8'h12, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[3]  = '{8'h13, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[4]  = '{8'h20, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[5]  = '{8'h0F, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[6]  = '{8'h11, 8'hFF, 1'b1, RMASK, 1'b1};
        vt[7]  = '{8'h11, 8'h00, 1'b0, 8'h0F, 1'b1};
        vt[8]  = '{8'h13, 8'hAA, 1'b1, 8'h00, 1'b1};
        vt[9]  = '{8'h11, 8'h00, 1'b0, 8'h0F, 1'b1};
        vt[10] = '{8'h12, 8'h55, 1'b1, 8'h00, 1'b1};
        vt[11] = '{8'h12, 8'h00, 1'b0, 8'h00, 1'b1};
        vt[12] = '{8'h11, 8'h05, 1'b1, 8'h0F, 1'b1};
        vt[13] = '{8'h14, 8'h00, 1'b0, 8'h00, 1'b0};
        vt[14] = '{8'h11, 8'h00, 1'b0, 8'h05, 1'b1};
        vt[15] = '{8'h10, 8'hFF, 1'b1, 8'h00, 1'b1};

        rst = 1'b1;
        bus.src_in = '0; bus.port_id = 8'h00; bus.out_port = 8'h00;
        bus.write_strobe = 1'b0; bus.interrupt_ack = 1'b0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;

        // Reset then idle: rotate reads over offsets 0..2 for 100 cycles.
        for (int c = 0; c < 100; c++) begin
            bus.port_id = BASE + 8'(c % 3);
            tick();
        end
        chk("idle_interrupt", bus.interrupt, 1'b0);
        rd_chk("idle_pending", 2'd0, 8'h00);
        rd_chk("idle_mask", 2'd1, RMASK);
        rd_chk("idle_vector", 2'd2, 8'h00);

        // Table-driven register accesses.
        for (int i = 0; i < 16; i++) begin
            bus.port_id = vt[i].port; bus.out_port = vt[i].data; bus.write_strobe = vt[i].we;
            #1;
            chk($sformatf("vec%0d_rd", i), bus.rd_data, vt[i].exp_rd);
            chk($sformatf("vec%0d_sel", i), bus.sel, vt[i].exp_sel);
            tick();
            bus.write_strobe = 1'b0;
        end

        // Single source: interrupt exactly 3 edges after the first sample.
        wr(8'h11, 8'h0F);
        bus.src_in = 4'b0100;
        tick(); chk("lat_n", bus.interrupt, 1'b0);
        tick(); chk("lat_n1", bus.interrupt, 1'b0);
        tick(); chk("lat_n2", bus.interrupt, 1'b0);
        rd_chk("lat_pending", 2'd0, 8'h04);
        bus.src_in = '0;
        tick(); chk("lat_n3", bus.interrupt, 1'b1);
        ack();
        chk("ack_drop", bus.interrupt, 1'b0);
        rd_chk("ack_vector", 2'd2, 8'hC2);
        rd_chk("ack_pending", 2'd0, 8'h00);
        wr(8'h12, 8'h00);
        rd_chk("eoi_vector", 2'd2, 8'h82);
        repeat (3) tick();
        chk("eoi_quiet", bus.interrupt, 1'b0);

        // Priority: sources 3 and 1 together; 1 is served first.
        pulse(4'b1010, 3);
        wait_intr("prio_wait1", 10);
        ack();
        rd_chk("prio_first", 2'd2, 8'hC1);
        wr(8'h12, 8'h00);
        chk("prio_eoi_k1", bus.interrupt, 1'b0);
        tick();
        chk("prio_eoi_k2", bus.interrupt, 1'b1);
        ack();
        rd_chk("prio_second", 2'd2, 8'hC3);
        wr(8'h12, 8'h00);

        // Masking: pending accumulates while masked; unmask raises at the next edge.
        wr(8'h11, 8'h00);
        pulse(4'b0001, 3);
        repeat (3) tick();
        rd_chk("mask_pending", 2'd0, 8'h01);
        chk("mask_quiet", bus.interrupt, 1'b0);
        wr(8'h11, 8'h01);
        chk("unmask_k", bus.interrupt, 1'b0);
        tick();
        chk("unmask_k1", bus.interrupt, 1'b1);
        ack();
        rd_chk("unmask_vector", 2'd2, 8'hC0);
        wr(8'h12, 8'h00);

        // Collision: W1C in the same cycle as a new edge leaves the bit set.
        wr(8'h11, 8'h00);
        pulse(4'b0001, 3);
        repeat (3) tick();
        bus.src_in = 4'b0001;
        tick(); tick();
        wr(8'h10, 8'h01);
        bus.src_in = '0;
        rd_chk("w1c_collide", 2'd0, 8'h01);
        repeat (3) tick();
        wr(8'h10, 8'h01);
        rd_chk("w1c_plain", 2'd0, 8'h00);

        // Masking the only source while requesting returns the FSM to idle.
        wr(8'h11, 8'h01);
        pulse(4'b0001, 3);
        wait_intr("assert_wait", 10);
        wr(8'h11, 8'h00);
        chk("maskoff_k", bus.interrupt, 1'b1);
        tick();
        chk("maskoff_k1", bus.interrupt, 1'b0);
        rd_chk("maskoff_pending", 2'd0, 8'h01);
        wr(8'h11, 8'h01);
        chk("remask_k", bus.interrupt, 1'b0);
        tick();
        chk("remask_k1", bus.interrupt, 1'b1);
        ack();
        wr(8'h12, 8'h00);

        // Reset mid-service with source 2 still pending.
        wr(8'h11, 8'h0F);
        pulse(4'b0101, 3);
        wait_intr("svc_wait", 10);
        ack();
        rd_chk("svc_pending", 2'd0, 8'h04);
        rd_chk("svc_vector", 2'd2, 8'hC0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_interrupt", bus.interrupt, 1'b0);
        rd_chk("rst_pending", 2'd0, 8'h00);
        rd_chk("rst_mask", 2'd1, RMASK);
        rd_chk("rst_vector", 2'd2, 8'h00);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("rst_quiet", bus.interrupt, 1'b0);

        // Randomized traffic against the model.
        wr(8'h11, 8'h0F);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 5) == 0) bus.src_in[b] = ~bus.src_in[b];
            bus.port_id = ($urandom_range(0, 7) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(0, 3));
            bus.out_port = 8'($urandom);
            bus.write_strobe = ($urandom_range(0, 5) == 0);
            if (m_mode == 1) bus.interrupt_ack = ($urandom_range(0, 2) == 0);
            else             bus.interrupt_ack = ($urandom_range(0, 15) == 0);
            tick();
        end
        bus.write_strobe = 1'b0; bus.interrupt_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
